// File: rtl/fetch_unit.sv
// Instruction fetch and prefetch buffer: 32-bit word fetch over req/ack, split into a halfword FIFO.
// Optional build macro FETCH_PC_CHECK_EN adds pc_in / pc_mismatch_out consistency checking.
module fetch_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_addr_in,
    output logic        stall_out,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    output logic        instr_valid_out,
    output logic [15:0] instr_out,
    output logic [31:0] instr_addr_out,
    input  logic        decode_stall_in
`ifdef FETCH_PC_CHECK_EN
    ,
    output logic        pc_mismatch_out,
    input  logic [31:0] pc_in
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(DEPTH);

    logic [15:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next, wr_ptr_plus1;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [31:0]       fetch_addr_reg, fetch_addr_next;
    logic [31:0]       head_addr_reg, head_addr_next;
    logic [31:0]       req_addr_reg, req_addr_next;
    logic              discard_reg, discard_next;
    logic              half_skip_reg, half_skip_next;
    logic              req_reg, req_next;
    logic              ack, pop, accept;
    logic [1:0]        push_num;
    logic [15:0]       push_first;
    logic [DEPTH-1:0]  we_first, we_second;

    assign ack          = req_reg && imem_ack_in;
    assign pop          = (count_reg != '0) && !decode_stall_in;
    assign accept       = ack && !discard_reg && !branch_taken_in;
    assign push_first   = half_skip_reg ? imem_rdata_in[31:16] : imem_rdata_in[15:0];
    assign push_num     = !accept ? 2'd0 : (half_skip_reg ? 2'd1 : 2'd2);
    assign wr_ptr_plus1 = wr_ptr_reg + PTR_W'(1);

    always_comb begin
        rd_ptr_next     = rd_ptr_reg;
        wr_ptr_next     = wr_ptr_reg;
        count_next      = count_reg;
        fetch_addr_next = fetch_addr_reg;
        head_addr_next  = head_addr_reg;
        discard_next    = discard_reg;
        half_skip_next  = half_skip_reg;
        req_next        = req_reg;
        req_addr_next   = req_addr_reg;

        if (branch_taken_in) begin
            rd_ptr_next     = '0;
            wr_ptr_next     = '0;
            count_next      = '0;
            head_addr_next  = branch_target_addr_in & ~32'h1;
            fetch_addr_next = branch_target_addr_in & ~32'h3;
            half_skip_next  = branch_target_addr_in[1];
            // An in-flight request still has to drain; its data belongs to the old stream.
            discard_next    = req_reg && !ack;
        end else begin
            if (ack) discard_next = 1'b0;
            if (accept) begin
                fetch_addr_next = fetch_addr_reg + 32'd4;
                half_skip_next  = 1'b0;
            end
            wr_ptr_next = wr_ptr_reg + PTR_W'(push_num);
            count_next  = count_reg + CNT_W'(push_num) - CNT_W'(pop);
            if (pop) begin
                rd_ptr_next    = rd_ptr_reg + PTR_W'(1);
                head_addr_next = head_addr_reg + 32'd2;
            end
        end

        // A held request keeps address and strobe until acked; otherwise reissue on space.
        if (!(req_reg && !ack)) begin
            req_next      = ((CNT_W+1)'(count_next) + (CNT_W+1)'(2)) <= DEPTH_L;
            req_addr_next = fetch_addr_next;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign we_first[gi]  = (push_num != 2'd0) && (wr_ptr_reg == PTR_W'(gi));
        assign we_second[gi] = (push_num == 2'd2) && (wr_ptr_plus1 == PTR_W'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we_first[i]) fifo_mem[i] <= push_first;
            else if (we_second[i]) fifo_mem[i] <= imem_rdata_in[31:16];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            fetch_addr_reg <= '0;
            head_addr_reg  <= '0;
            discard_reg    <= 1'b0;
            half_skip_reg  <= 1'b0;
            req_reg        <= 1'b0;
            req_addr_reg   <= '0;
        end else begin
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            count_reg      <= count_next;
            fetch_addr_reg <= fetch_addr_next;
            head_addr_reg  <= head_addr_next;
            discard_reg    <= discard_next;
            half_skip_reg  <= half_skip_next;
            req_reg        <= req_next;
            req_addr_reg   <= req_addr_next;
        end
    end

    assign imem_req_out    = req_reg;
    assign imem_addr_out   = req_addr_reg;
    assign instr_valid_out = (count_reg != '0);
    assign instr_out       = instr_valid_out ? fifo_mem[rd_ptr_reg] : 16'h0000;
    assign instr_addr_out  = head_addr_reg;
    // PC advances exactly when a halfword is consumed; a branch always loads the PC.
    assign stall_out       = !branch_taken_in && !(instr_valid_out && !decode_stall_in);

`ifdef FETCH_PC_CHECK_EN
    logic pc_mismatch_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_mismatch_reg <= 1'b0;
        end else if (instr_valid_out && (pc_in != head_addr_reg)) begin
            pc_mismatch_reg <= 1'b1;
        end
    end

    assign pc_mismatch_out = pc_mismatch_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model compared every cycle, plus directed literal checks.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_taken_in = 1'b0;
    logic [31:0] branch_target_addr_in = 32'h0;
    logic        stall_out;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in = 1'b0;
    logic [31:0] imem_rdata_in = 32'h0;
    logic        instr_valid_out;
    logic [15:0] instr_out;
    logic [31:0] instr_addr_out;
    logic        decode_stall_in = 1'b0;
`ifdef FETCH_PC_CHECK_EN
    logic        pc_mismatch_out;
    logic [31:0] pc_in;
    logic        pc_force = 1'b0;
    logic [31:0] pc_force_val = 32'h0;
    assign pc_in = pc_force ? pc_force_val : instr_addr_out;
`endif

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .branch_taken_in(branch_taken_in),
        .branch_target_addr_in(branch_target_addr_in),
        .stall_out(stall_out),
        .imem_req_out(imem_req_out),
        .imem_addr_out(imem_addr_out),
        .imem_ack_in(imem_ack_in),
        .imem_rdata_in(imem_rdata_in),
        .instr_valid_out(instr_valid_out),
        .instr_out(instr_out),
        .instr_addr_out(instr_addr_out),
        .decode_stall_in(decode_stall_in)
`ifdef FETCH_PC_CHECK_EN
        ,
        .pc_mismatch_out(pc_mismatch_out),
        .pc_in(pc_in)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ack_lat = 0;
    int wait_cnt = 0;
    int ack_count = 0;
    bit chk_en = 0;

    // Halfword at address a reads a ^ 16'h5A00, except word 0 which holds a known program.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hB501_2001;
        return {(a[15:0] + 16'd2) ^ 16'h5A00, a[15:0] ^ 16'h5A00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    // Memory: acks a request after ack_lat wait cycles.
    initial forever begin
        @(negedge clk);
        if (imem_req_out === 1'b1) begin
            if (wait_cnt >= ack_lat) begin
                imem_ack_in   = 1'b1;
                imem_rdata_in = mem_word(imem_addr_out);
                wait_cnt      = 0;
                ack_count++;
            end else begin
                imem_ack_in = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_ack_in = 1'b0;
            wait_cnt    = 0;
        end
    end

    // Reference model: a queue of (address, halfword) pairs.
    typedef struct {
        logic [31:0] a;
        logic [15:0] d;
    } hw_t;
    hw_t         q[$];
    logic [31:0] m_head = 0, m_fetch = 0, m_reqaddr = 0;
    bit          m_half = 0, m_disc = 0, m_req = 0, m_mis = 0;

    task automatic model_step();
        bit ack;
        logic [31:0] w;
        hw_t h;
        if (rst) begin
            q.delete();
            m_head = 0; m_fetch = 0; m_reqaddr = 0;
            m_half = 0; m_disc = 0; m_req = 0; m_mis = 0;
            return;
        end
        ack = m_req && imem_ack_in;
`ifdef FETCH_PC_CHECK_EN
        if (q.size() != 0 && (pc_force ? pc_force_val : m_head) != m_head) m_mis = 1;
`endif
        if (branch_taken_in) begin
            q.delete();
            m_head  = branch_target_addr_in & ~32'h1;
            m_fetch = branch_target_addr_in & ~32'h3;
            m_half  = branch_target_addr_in[1];
            m_disc  = m_req && !ack;
        end else begin
            if (q.size() != 0 && !decode_stall_in) begin
                void'(q.pop_front());
                m_head = m_head + 2;
            end
            if (ack) begin
                if (m_disc) begin
                    m_disc = 0;
                end else begin
                    w = imem_rdata_in;
                    if (!m_half) begin
                        h.a = m_fetch; h.d = w[15:0];
                        q.push_back(h);
                    end
                    h.a = m_fetch + 2; h.d = w[31:16];
                    q.push_back(h);
                    m_fetch = m_fetch + 4;
                    m_half  = 0;
                end
            end
        end
        if (!(m_req && !ack)) begin
            m_req     = (q.size() + 2 <= DEPTH);
            m_reqaddr = m_fetch;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (chk_en) begin
            logic [15:0] exp_instr;
            exp_instr = 16'h0;
            if (q.size() != 0) exp_instr = q[0].d;
            check("valid", instr_valid_out, (q.size() != 0));
            check("instr", instr_out, exp_instr);
            check("iaddr", instr_addr_out, m_head);
            check("stall", stall_out, !branch_taken_in && !(q.size() != 0 && !decode_stall_in));
            check("req", imem_req_out, m_req);
            if (m_req) check("req_addr", imem_addr_out, m_reqaddr);
`ifdef FETCH_PC_CHECK_EN
            check("pc_mis", pc_mismatch_out, m_mis);
`endif
        end
    end

    task automatic reset_release();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        int base;
        bit saw_target;
        repeat (2) @(negedge clk);
        chk_en = 1;
        #3;
        check("rst_req", imem_req_out, 0);
        check("rst_addr", imem_addr_out, 32'h0);
        check("rst_valid", instr_valid_out, 0);
        check("rst_iaddr", instr_addr_out, 32'h0);

        // Zero-wait fetch of word 0 after reset release
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #3;
        check("a_req", imem_req_out, 1);
        check("a_addr", imem_addr_out, 32'h0);
        check("a_nvalid", instr_valid_out, 0);
        @(negedge clk); #3;
        check("a_i0", instr_out, 16'h2001);
        check("a_a0", instr_addr_out, 32'h0);
        check("a_s0", stall_out, 0);
        @(negedge clk); #3;
        check("a_i1", instr_out, 16'hB501);
        check("a_a1", instr_addr_out, 32'h2);
        check("a_s1", stall_out, 0);

        // Decode stalled: buffer fills with exactly two words
        decode_stall_in = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #3; ack_count = 0;
        @(negedge clk); rst = 1'b0;
        repeat (8) @(negedge clk);
        #3;
        check("b_words", ack_count, 2);
        check("b_req", imem_req_out, 0);
        check("b_stall", stall_out, 1);
        check("b_instr", instr_out, 16'h2001);

        // Branch to an odd halfword of a word
        @(negedge clk);
        branch_taken_in = 1'b1; branch_target_addr_in = 32'h0000_0102; decode_stall_in = 1'b0;
        #3; check("c_stall", stall_out, 0);
        @(negedge clk); branch_taken_in = 1'b0;
        #3;
        check("c_req", imem_req_out, 1);
        check("c_addr", imem_addr_out, 32'h0000_0100);
        @(negedge clk); #3;
        check("c_iaddr", instr_addr_out, 32'h0000_0102);
        check("c_instr", instr_out, 16'h5B02);
        @(negedge clk); #3;
        check("c_next", instr_addr_out, 32'h0000_0104);

        // Branch while a slow request to 0x8 is pending
        ack_lat = 0; decode_stall_in = 1'b1;
        reset_release();
        repeat (4) @(negedge clk);
        ack_lat = 3; decode_stall_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #3;
            if (imem_req_out) break;
        end
        check("d_pend", imem_addr_out, 32'h8);
        branch_taken_in = 1'b1; branch_target_addr_in = 32'h0000_0040;
        @(negedge clk); branch_taken_in = 1'b0;
        base = ack_count; saw_target = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #3;
            if (imem_req_out && imem_addr_out == 32'h40) saw_target = 1;
            if (instr_valid_out) break;
        end
        check("d_valid", instr_valid_out, 1);
        check("d_iaddr", instr_addr_out, 32'h40);
        check("d_instr", instr_out, 16'h5A40);
        check("d_acks", ack_count - base, 2);
        check("d_target_req", saw_target, 1);

        // Branch coinciding with an ack
        ack_lat = 0; decode_stall_in = 1'b1;
        reset_release();
        @(negedge clk);
        branch_taken_in = 1'b1; branch_target_addr_in = 32'h0000_0020;
        #3; check("e_ack_now", imem_ack_in, 1);
        @(negedge clk); branch_taken_in = 1'b0;
        #3;
        check("e_empty", instr_valid_out, 0);
        check("e_req", imem_req_out, 1);
        check("e_addr", imem_addr_out, 32'h20);
        @(negedge clk); #3;
        check("e_instr", instr_out, 16'h5A20);
        check("e_iaddr", instr_addr_out, 32'h20);

`ifdef FETCH_PC_CHECK_EN
        decode_stall_in = 1'b0;
        reset_release();
        repeat (3) @(negedge clk);
        #3;
        decode_stall_in = 1'b1;
        check("f_head", instr_addr_out, 32'h2);
        pc_force = 1'b1; pc_force_val = 32'h4;
        @(negedge clk); #3;
        check("f_mis", pc_mismatch_out, 1);
        pc_force = 1'b0;
        repeat (2) @(negedge clk);
        #3; check("f_sticky", pc_mismatch_out, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #3;
        check("f_clear", pc_mismatch_out, 0);
        rst = 1'b0;
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and prefetch buffer for the Cortex-M0 core. The block sits between instruction memory and the PC/decode stages. It fetches 32-bit words from instruction memory over a req/ack interface and splits them into 16-bit Thumb halfwords in a small FIFO. It presents one instruction per cycle to decode and drives the stall that freezes the program counter whenever no instruction is consumed. Branch redirects flush the buffer and restart fetch at the target.

## Interface
- DEPTH, 4, prefetch FIFO depth in halfwords; power of two, ≥ 4
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active-high
- branch_taken_in  in  1  redirect fetch this cycle
- branch_target_addr_in  in  32  redirect target; bit 0 ignored
- stall_out  out  1  freeze program counter (to PC unit stall input)
- imem_req_out  out  1  memory read request; held until ack
- imem_addr_out  out  32  word address, bits [1:0] always 0
- imem_ack_in  in  1  read completes this cycle; only valid while imem_req_out=1
- imem_rdata_in  in  32  read data, valid with ack
- instr_valid_out  out  1  instr_out holds a valid halfword
- instr_out  out  16  current Thumb halfword
- instr_addr_out  out  32  address of instr_out, bit 0 always 0
- decode_stall_in  in  1  decode cannot accept this cycle
- pc_mismatch_out  out  1  sticky consistency error (only with FETCH_PC_CHECK_EN)
- pc_in  in  32  current PC value (only with FETCH_PC_CHECK_EN)

## Operation
- State: `fetch_addr` (word-aligned), `head_addr`, FIFO with `count` 0..DEPTH, `discard` flag, `half_skip` flag.
- Reset: `fetch_addr`=0, `head_addr`=0, `count`=0, `discard`=0, `half_skip`=0, imem_req_out=0, imem_addr_out=0, pc_mismatch_out=0.
- Request: imem_req_out is registered.
  - Asserted for the next cycle when `count_next` + 2 ≤ DEPTH, where `count_next` includes this cycle's push and pop.
  - Once high, imem_req_out and imem_addr_out hold until imem_ack_in. At most one request is outstanding.
- Ack without discard:
  - Push imem_rdata_in[15:0], then [31:16], as little-endian halfwords.
  - If `half_skip`=1, push only [31:16] and clear `half_skip`.
  - `fetch_addr` += 4 (wraps modulo 2^32).
- Ack with `discard`=1: drop the data, clear `discard`, leave FIFO untouched.
- Output:
  - instr_valid_out = (`count` != 0).
  - instr_out = FIFO head, or 16'h0000 when empty.
  - instr_addr_out = `head_addr`.
- Pop: when instr_valid_out && !decode_stall_in; `head_addr` += 2. Push and pop in the same cycle are both performed.
- stall_out = !branch_taken_in && !(instr_valid_out && !decode_stall_in). This is combinational, so the PC advances by 2 exactly when a halfword is consumed, and a branch is never masked by a stall.
- Branch (priority over push and pop in the same cycle):
  - `count`=0.
  - `head_addr` = target & ~1.
  - `fetch_addr` = target & ~3.
  - `half_skip` = target[1].
  - If a request is outstanding and not acked this cycle, set `discard`=1. The held request completes normally; the new fetch is issued only after that ack.
  - If acked in the same cycle, the ack data is dropped and `discard` stays 0.
- Reset mid-transfer: all state clears and imem_req_out drops. Memory must tolerate an abandoned request.

## Timing
- Zero-wait memory (ack in the same cycle as req), from rst falling before edge E0:
  - imem_req_out=1 after E0.
  - Push at E1.
  - instr_valid_out=1 after E1.
- Sustained throughput: one word per cycle while space allows.
  - Decode consumes one halfword per cycle.
  - FIFO occupancy settles; no bubbles with zero-wait memory and DEPTH ≥ 4.
- Branch to delivery, with zero-wait memory and no outstanding request: new request after the branch edge, first target halfword valid one edge later (2 cycles).
- Each memory wait cycle adds one cycle of latency.

## Configuration
- FETCH_PC_CHECK_EN defined:
  - pc_in and pc_mismatch_out exist.
  - When instr_valid_out=1 and pc_in != instr_addr_out, pc_mismatch_out is set and stays 1 until rst.
- Undefined: both ports are absent and there is no check logic.

## Test plan
- Reset release, zero-wait memory returning 32'hB501_2001 at address 0:
  - instr_out=16'h2001 at addr 0, then 16'hB501 at addr 2.
  - stall_out=0 on both consuming cycles.
- decode_stall_in held 1 with DEPTH=4:
  - Exactly two words fetched, count=4.
  - imem_req_out stays 0; stall_out=1 every cycle.
- Branch to 32'h0000_0102:
  - Request at 32'h0000_0100.
  - Only the upper halfword is delivered, with instr_addr_out=32'h0000_0102.
  - stall_out=0 in the branch cycle.
- Branch while a request to 0x8 is pending (ack 3 cycles later):
  - The 0x8 data is discarded.
  - The next request goes to the target word.
  - No stale halfword appears on instr_out.
- Branch and ack in the same cycle:
  - Ack data dropped, FIFO empty, discard=0.
  - New request issued on the following edge.
- With FETCH_PC_CHECK_EN: force pc_in=32'h4 while instr_addr_out=32'h2 and valid -> pc_mismatch_out=1 until rst.
